cb_hdr_parser: RTL and testbench
================================

Name: cb_hdr_parser

Overview:
Ingress stage for CB-framed traffic on a 64-bit AXI-Stream. Beat 0 of every packet is the 64-bit CB header. The block decodes it, checks the header type, the sequence number and the payload length, and forwards only the payload beats downstream. Per packet it publishes the decoded header fields and a status record; the statistics builder consumes that record.

Parameters:
DATA_W, 64, stream width; fixed, must equal the CB header width.
CB_HDR_TYPE, 2'b01, header_type value accepted as a CB header.
CNT_W, 32, width of the packet and error counters.

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  64  input beat; beat 0 carries the CB header
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of packet
m_axis_tdata  out  64  payload beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last payload beat
hdr_valid  out  1  one-cycle pulse: header fields valid
hdr_tb_index  out  8  decoded tb_index
hdr_seq_num  out  9  decoded sequence_number
hdr_tti  out  2  decoded tti
hdr_last_cb  out  1  decoded last_cb
hdr_in_len  out  16  input_code_length_bits
hdr_out_len  out  16  output_code_length_bits
sts_valid  out  1  one-cycle pulse at end of packet
sts_err  out  4  {type_err, seq_err, short_err, long_err}
pkt_cnt  out  CNT_W  packets completed
err_cnt  out  CNT_W  packets with any sts_err bit set

Behaviour:
- Header bit map, LSB first: header_type[1:0], reserved0[2], last_cb[3], tti[5:4], reserved1[7:6], tb_index[15:8], sequence_number[24:16], reserved2[31:25], input_code_length_bits[47:32], output_code_length_bits[63:48].
- Reset: FSM=IDLE; all outputs 0; expected seq=0; seq_init=0; counters 0.
- A handshake occurs when valid&ready are both high in the same cycle.
- IDLE:
  - s_axis_tready=1.
  - On header handshake, compute exp_beats = ceil(in_len/64) = (in_len+63)>>6, 17-bit arithmetic.
  - If header_type!=CB_HDR_TYPE: type_err; go to DROP, or if tlast, end immediately. hdr_valid stays low.
  - Otherwise: assert hdr_valid next cycle with the decoded fields.
  - seq_err when seq_init=1 and sequence_number != expected seq.
  - Then expected seq <= sequence_number+1 mod 512 and seq_init<=1. The expected seq resyncs to the received value even on a mismatch.
- Header beat with tlast:
  - exp_beats==0: packet complete, no payload emitted.
  - exp_beats>0: short_err, packet complete.
  - Otherwise, with exp_beats==0: long_err; go to DROP.
  - Otherwise: go to PAYLOAD with beat_cnt=0.
- PAYLOAD:
  - s_axis_tready = !m_axis_tvalid | m_axis_tready (one-stage output register; latency 1 cycle, full throughput).
  - Each accepted beat is loaded into the output register and increments beat_cnt.
  - Beat with tlast and beat_cnt+1 < exp_beats: forwarded with m_axis_tlast=1; short_err; packet complete; go to IDLE.
  - Beat with beat_cnt+1 == exp_beats:
    - forwarded with m_axis_tlast=1;
    - if tlast, clean completion to IDLE;
    - if not tlast, long_err and go to DROP.
- DROP: s_axis_tready=1. Beats are discarded, none output. On tlast, packet complete; go to IDLE.
- Packet complete:
  - sts_valid pulses the next cycle with the accumulated sts_err.
  - pkt_cnt increments.
  - err_cnt increments if sts_err!=0.
  - Counters wrap at 2^CNT_W.
- m_axis_tvalid holds until m_axis_tready. The held tdata/tlast are stable while stalled.
- Back-to-back packets: the header of packet N+1 may be accepted while the last payload beat of packet N is still held in the output register.
- rst mid-packet: returns to IDLE, clears the output register and pending pulses, and resets seq_init. The rest of the interrupted packet arriving after reset is parsed as a new header; this is acceptable.
- reserved fields are ignored.

Test Plan:
1. Header type=1, seq=0, in_len=128, then 2 beats with tlast on beat 2 -> hdr_valid with in_len=128; 2 beats out, tlast on 2nd; sts_err=0; pkt_cnt=1.
2. Packets with seq=5 then seq=7, in_len=64, 1 beat each -> 2nd sts_err=4'b0100; err_cnt=1; a following seq=8 packet is clean.
3. in_len=200 (exp 4), tlast on beat 2 -> 2 beats out, last with tlast; sts_err=4'b0010.
4. in_len=64, 3 payload beats, tlast on 3rd -> 1 beat out with tlast; beats 2-3 dropped; sts_err=4'b0001.
5. header_type=2, 3 beats -> no hdr_valid, no output; sts_err=4'b1000.
6. m_axis_tready toggles 1010 during a 4-beat payload, then rst asserted mid-packet -> data order and stability held under stall; after rst all outputs 0, state IDLE, and the next seq is accepted without seq_err.

Source files
------------

// File: rtl/cb_hdr_parser.sv
// CB header parser: strips the 64-bit CB header from each AXI-Stream packet,
// publishes the decoded fields, checks type/sequence/length and forwards the payload.
module cb_hdr_parser #(
  parameter int         DATA_W      = 64,
  parameter logic [1:0] CB_HDR_TYPE = 2'b01,
  parameter int         CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              hdr_valid,
  output logic [7:0]        hdr_tb_index,
  output logic [8:0]        hdr_seq_num,
  output logic [1:0]        hdr_tti,
  output logic              hdr_last_cb,
  output logic [15:0]       hdr_in_len,
  output logic [15:0]       hdr_out_len,
  output logic              sts_valid,
  output logic [3:0]        sts_err,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake rule on both ports: a beat transfers on a cycle where valid and
  // ready are both high; a raised valid holds its data until that happens.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] exp_beats, exp_beats_nxt;
  logic [11:0] beat_cnt, beat_cnt_nxt;
  logic [11:0] cnt_inc;
  logic [11:0] hdr_beats;
  logic [3:0]  err_acc, err_acc_nxt;
  logic [3:0]  hdr_err;
  logic [3:0]  done_err;
  logic [8:0]  exp_seq;
  logic        seq_init;
  logic        s_hs, type_ok, seq_bad;
  logic        done, hdr_take, out_load, out_last;

  assign dbg_state = state;

  always_comb begin
    s_axis_tready = 1'b1;
    if (state == ST_PAYLOAD) s_axis_tready = !m_axis_tvalid || m_axis_tready;
    s_hs      = s_axis_tvalid && s_axis_tready;
    hdr_beats = 12'((17'(s_axis_tdata[47:32]) + 17'd63) >> 6);
    type_ok   = (s_axis_tdata[1:0] == CB_HDR_TYPE);
    seq_bad   = seq_init && (s_axis_tdata[24:16] != exp_seq);
    cnt_inc   = beat_cnt + 12'd1;
    hdr_err   = {1'b0, seq_bad, 2'b00};

    state_nxt     = state;
    exp_beats_nxt = exp_beats;
    beat_cnt_nxt  = beat_cnt;
    err_acc_nxt   = err_acc;
    done          = 1'b0;
    done_err      = err_acc;
    hdr_take      = 1'b0;
    out_load      = 1'b0;
    out_last      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s_hs) begin
          if (!type_ok) begin
            // Unknown header type: no field decode, no sequence tracking.
            if (s_axis_tlast) begin
              done     = 1'b1;
              done_err = 4'b1000;
            end else begin
              err_acc_nxt = 4'b1000;
              state_nxt   = ST_DROP;
            end
          end else begin
            hdr_take      = 1'b1;
            exp_beats_nxt = hdr_beats;
            beat_cnt_nxt  = 12'd0;
            if (s_axis_tlast) begin
              done     = 1'b1;
              done_err = hdr_err | ((hdr_beats != 12'd0) ? 4'b0010 : 4'b0000);
            end else if (hdr_beats == 12'd0) begin
              err_acc_nxt = hdr_err | 4'b0001;
              state_nxt   = ST_DROP;
            end else begin
              err_acc_nxt = hdr_err;
              state_nxt   = ST_PAYLOAD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (s_hs) begin
          out_load     = 1'b1;
          beat_cnt_nxt = cnt_inc;
          if (cnt_inc == exp_beats) begin
            out_last = 1'b1;
            if (s_axis_tlast) begin
              done      = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              err_acc_nxt = err_acc | 4'b0001;
              state_nxt   = ST_DROP;
            end
          end else if (s_axis_tlast) begin
            out_last  = 1'b1;
            done      = 1'b1;
            done_err  = err_acc | 4'b0010;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (s_hs && s_axis_tlast) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      exp_beats     <= '0;
      beat_cnt      <= '0;
      err_acc       <= '0;
      exp_seq       <= '0;
      seq_init      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      hdr_valid     <= 1'b0;
      hdr_tb_index  <= '0;
      hdr_seq_num   <= '0;
      hdr_tti       <= '0;
      hdr_last_cb   <= 1'b0;
      hdr_in_len    <= '0;
      hdr_out_len   <= '0;
      sts_valid     <= 1'b0;
      sts_err       <= '0;
      pkt_cnt       <= '0;
      err_cnt       <= '0;
    end else begin
      state     <= state_nxt;
      exp_beats <= exp_beats_nxt;
      beat_cnt  <= beat_cnt_nxt;
      err_acc   <= err_acc_nxt;

      hdr_valid <= hdr_take;
      if (hdr_take) begin
        // Expected sequence resyncs to the received value even on a mismatch.
        exp_seq      <= s_axis_tdata[24:16] + 9'd1;
        seq_init     <= 1'b1;
        hdr_tb_index <= s_axis_tdata[15:8];
        hdr_seq_num  <= s_axis_tdata[24:16];
        hdr_tti      <= s_axis_tdata[5:4];
        hdr_last_cb  <= s_axis_tdata[3];
        hdr_in_len   <= s_axis_tdata[47:32];
        hdr_out_len  <= s_axis_tdata[63:48];
      end

      sts_valid <= done;
      if (done) begin
        sts_err <= done_err;
        pkt_cnt <= pkt_cnt + CNT_W'(1);
        if (done_err != 4'b0000) err_cnt <= err_cnt + CNT_W'(1);
      end

      if (out_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tlast  <= out_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cb_hdr_parser.sv
// Bench for cb_hdr_parser: packet-level reference model, per-cycle compare
// process, directed scenarios followed by randomized traffic.
module tb_cb_hdr_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        hdr_valid;
  logic [7:0]  hdr_tb_index;
  logic [8:0]  hdr_seq_num;
  logic [1:0]  hdr_tti;
  logic        hdr_last_cb;
  logic [15:0] hdr_in_len;
  logic [15:0] hdr_out_len;
  logic        sts_valid;
  logic [3:0]  sts_err;
  logic [31:0] pkt_cnt;
  logic [31:0] err_cnt;
  logic [1:0]  dbg_state;

  cb_hdr_parser dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .hdr_valid(hdr_valid), .hdr_tb_index(hdr_tb_index), .hdr_seq_num(hdr_seq_num),
    .hdr_tti(hdr_tti), .hdr_last_cb(hdr_last_cb), .hdr_in_len(hdr_in_len),
    .hdr_out_len(hdr_out_len), .sts_valid(sts_valid), .sts_err(sts_err),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [64:0]  exp_q[$];   // {tlast, tdata}
  logic [51:0]  hdr_q[$];   // {tb_index, seq, tti, last_cb, in_len, out_len}
  logic [67:0]  sts_q[$];   // {sts_err, pkt_cnt, err_cnt}
  logic [63:0]  pl_q[$];

  bit          m_seq_init;
  logic [8:0]  m_exp_seq;
  logic [31:0] m_pkt, m_errc;

  int          ready_mode = 0;
  int          pat_idx = 0;
  logic [3:0]  last_sts_err = '0;
  logic [15:0] last_hdr_in_len = '0;
  int          out_seen = 0;
  int          hdr_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none/timely", name);
  endtask

  // Packet-level reference: whole packet in, expected outputs queued.
  task automatic model_pkt(input logic [63:0] hdr, output logic [3:0] err);
    int n, eb, fwd;
    logic [8:0] seq;
    err = 4'b0000;
    n = pl_q.size();
    if (hdr[1:0] != 2'b01) begin
      err = 4'b1000;
    end else begin
      seq = hdr[24:16];
      hdr_q.push_back({hdr[15:8], seq, hdr[5:4], hdr[3], hdr[47:32], hdr[63:48]});
      if (m_seq_init && seq != m_exp_seq) err[2] = 1'b1;
      m_exp_seq = seq + 9'd1;
      m_seq_init = 1'b1;
      eb = (int'(hdr[47:32]) + 63) / 64;
      if (n == 0) begin
        if (eb > 0) err[1] = 1'b1;
      end else if (eb == 0) begin
        err[0] = 1'b1;
      end else begin
        fwd = (n < eb) ? n : eb;
        for (int i = 0; i < fwd; i++) exp_q.push_back({(i == fwd - 1), pl_q[i]});
        if (n < eb) err[1] = 1'b1;
        if (n > eb) err[0] = 1'b1;
      end
    end
    m_pkt++;
    if (err != 4'b0000) m_errc++;
    sts_q.push_back({err, m_pkt, m_errc});
  endtask

  function automatic logic [63:0] mk_hdr(input logic [1:0] typ, input logic [8:0] seq,
                                         input logic [15:0] in_len);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[1:0]   = typ;
    h[24:16] = seq;
    h[47:32] = in_len;
    return h;
  endfunction

  // All driver tasks start and end just after a rising edge.
  task automatic wait_hs();
    bit hs;
    int t;
    t = 0;
    do begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 500);
    if (!hs) fail_now("s_handshake_timeout");
  endtask

  task automatic drive_pkt(input logic [63:0] hdr, input int n, input int abort_after,
                           output logic [3:0] err);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back({$urandom, $urandom});
    model_pkt(hdr, err);
    for (int b = 0; b <= n; b++) begin
      if (abort_after >= 0 && b == abort_after + 1) break;
      if ($urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = (b == 0) ? hdr : pl_q[b-1];
      s_axis_tlast  = (b == n);
      wait_hs();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    exp_q.delete();
    hdr_q.delete();
    sts_q.delete();
    m_seq_init = 1'b0;
    m_exp_seq = '0;
    m_pkt = '0;
    m_errc = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_m_valid"}, m_axis_tvalid, 1'b0);
    check({tag, "_m_data"}, {m_axis_tlast, m_axis_tdata}, 65'd0);
    check({tag, "_hdr_valid"}, hdr_valid, 1'b0);
    check({tag, "_hdr_fields"}, {hdr_tb_index, hdr_seq_num, hdr_tti, hdr_last_cb, hdr_in_len, hdr_out_len}, 52'd0);
    check({tag, "_sts"}, {sts_valid, sts_err}, 5'd0);
    check({tag, "_counters"}, {pkt_cnt, err_cnt}, 64'd0);
    check({tag, "_state_idle"}, {dbg_state, s_axis_tready}, 3'b001);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || hdr_q.size() != 0 || sts_q.size() != 0) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0 || hdr_q.size() != 0 || sts_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      hdr_q.delete();
      sts_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ($urandom_range(0, 2) != 0);
      default: begin
        m_axis_tready = (pat_idx % 2 == 0);
        pat_idx++;
      end
    endcase
  end

  // Compare process: every cycle, outputs against the model queues.
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic        p_last  = 1'b0;
  logic [63:0] p_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        check("m_hold_valid", m_axis_tvalid, 1'b1);
        check("m_hold_data", {m_axis_tlast, m_axis_tdata}, {p_last, p_data});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_seen++;
        if (exp_q.size() == 0) fail_now("m_beat_unexpected");
        else check("m_beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
      if (hdr_valid) begin
        hdr_seen++;
        last_hdr_in_len = hdr_in_len;
        if (hdr_q.size() == 0) fail_now("hdr_unexpected");
        else check("hdr_fields", {hdr_tb_index, hdr_seq_num, hdr_tti, hdr_last_cb,
                                  hdr_in_len, hdr_out_len}, hdr_q.pop_front());
      end
      if (sts_valid) begin
        last_sts_err = sts_err;
        if (sts_q.size() == 0) fail_now("sts_unexpected");
        else check("sts_record", {sts_err, pkt_cnt, err_cnt}, sts_q.pop_front());
      end
      p_valid = m_axis_tvalid;
      p_ready = m_axis_tready;
      p_last  = m_axis_tlast;
      p_data  = m_axis_tdata;
    end
  end

  initial begin
    logic [3:0] err;
    int o0, h0, eb, n;
    logic [1:0] typ;
    logic [8:0] seq;
    logic [15:0] len;

    apply_reset(3);
    check_idle("reset");

    // 1: clean two-beat packet
    o0 = out_seen;
    drive_pkt(mk_hdr(2'b01, 9'd0, 16'd128), 2, -1, err);
    check("t1_model_err", err, 4'b0000);
    wait_drain();
    check("t1_sts_err", last_sts_err, 4'b0000);
    check("t1_pkt_cnt", pkt_cnt, 32'd1);
    check("t1_in_len", last_hdr_in_len, 16'd128);
    check("t1_beats_out", out_seen - o0, 2);

    // 2: sequence gap
    apply_reset(2);
    drive_pkt(mk_hdr(2'b01, 9'd5, 16'd64), 1, -1, err);
    drive_pkt(mk_hdr(2'b01, 9'd7, 16'd64), 1, -1, err);
    check("t2_model_err", err, 4'b0100);
    wait_drain();
    check("t2_sts_err", last_sts_err, 4'b0100);
    check("t2_err_cnt", err_cnt, 32'd1);
    drive_pkt(mk_hdr(2'b01, 9'd8, 16'd64), 1, -1, err);
    wait_drain();
    check("t2_clean_after", last_sts_err, 4'b0000);

    // 3: short packet
    o0 = out_seen;
    drive_pkt(mk_hdr(2'b01, 9'd9, 16'd200), 2, -1, err);
    check("t3_model_err", err, 4'b0010);
    wait_drain();
    check("t3_sts_err", last_sts_err, 4'b0010);
    check("t3_beats_out", out_seen - o0, 2);

    // 4: long packet
    o0 = out_seen;
    drive_pkt(mk_hdr(2'b01, 9'd10, 16'd64), 3, -1, err);
    check("t4_model_err", err, 4'b0001);
    wait_drain();
    check("t4_sts_err", last_sts_err, 4'b0001);
    check("t4_beats_out", out_seen - o0, 1);

    // 5: wrong header type
    o0 = out_seen;
    h0 = hdr_seen;
    drive_pkt(mk_hdr(2'b10, 9'd11, 16'd128), 2, -1, err);
    check("t5_model_err", err, 4'b1000);
    wait_drain();
    check("t5_sts_err", last_sts_err, 4'b1000);
    check("t5_no_output", {out_seen - o0, hdr_seen - h0}, 64'd0);

    // 6: output stall pattern, then reset mid-packet
    ready_mode = 2;
    o0 = out_seen;
    drive_pkt(mk_hdr(2'b01, 9'd11, 16'd256), 4, -1, err);
    wait_drain();
    check("t6_beats_out", out_seen - o0, 4);
    check("t6_sts_err", last_sts_err, 4'b0000);
    drive_pkt(mk_hdr(2'b01, 9'd12, 16'd256), 4, 2, err);
    @(posedge clk);
    #1;
    apply_reset(2);
    ready_mode = 0;
    check_idle("midrst");
    drive_pkt(mk_hdr(2'b01, 9'd300, 16'd64), 1, -1, err);
    check("t6_model_no_seq_err", err, 4'b0000);
    wait_drain();
    check("t6_sts_after_rst", last_sts_err, 4'b0000);
    check("t6_pkt_cnt", pkt_cnt, 32'd1);

    // Randomized traffic
    ready_mode = 1;
    for (int p = 0; p < 60; p++) begin
      typ = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      seq = ($urandom_range(0, 6) == 0) ? 9'($urandom) : m_exp_seq;
      case ($urandom_range(0, 4))
        0: len = 16'd0;
        1: len = 16'($urandom_range(1, 64));
        default: len = 16'($urandom_range(0, 600));
      endcase
      eb = (int'(len) + 63) / 64;
      n = ($urandom_range(0, 1) == 0) ? eb : $urandom_range(0, eb + 2);
      drive_pkt(mk_hdr(typ, seq, len), n, -1, err);
    end
    wait_drain();
    check("rand_pkt_cnt", pkt_cnt, m_pkt);
    check("rand_err_cnt", err_cnt, m_errc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
